dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one data-memory port among NUM_HARTS harts in the multi-core build.
//  Accepts one load/store request at a time and drives it to a variable-latency memory.
//  Returns the read data (or an error) to the requesting hart only.
//  Sits between the hart dmem interfaces and the single shared memory.
// PARAMETERS
//  NUM_HARTS  3   number of requesting harts (2..8)
//  ADDR_W     32  address width; addresses are word aligned (bits [1:0] forced to 0 on o_mem_addr)
// PORTS
//  i_clk          in   1              clock, all state on rising edge
//  i_rst_n        in   1              asynchronous active-low reset
//  i_req_valid    in   NUM_HARTS      per-hart request pending; held until o_req_ready
//  i_req_ren      in   NUM_HARTS      per-hart read request
//  i_req_wen      in   NUM_HARTS      per-hart write request
//  i_req_addr     in   NUM_HARTS*32   per-hart address; hart h uses [h*32 +: 32]
//  i_req_wdata    in   NUM_HARTS*32   per-hart write data, byte lanes pre-shifted
//  i_req_mask     in   NUM_HARTS*4    per-hart byte mask
//  o_req_ready    out  NUM_HARTS      one-hot, 1-cycle pulse: request of that hart accepted
//  o_rsp_valid    out  NUM_HARTS      one-hot, 1-cycle pulse: response for that hart
//  o_rsp_rdata    out  32             read data, valid with o_rsp_valid (0 for writes/errors)
//  o_rsp_err      out  1              request was illegal, valid with o_rsp_valid
//  o_mem_addr     out  32             shared memory address
//  o_mem_ren      out  1              memory read strobe, 1 cycle
//  o_mem_wen      out  1              memory write strobe, 1 cycle
//  o_mem_wdata    out  32             memory write data
//  o_mem_mask     out  4              memory byte mask
//  i_mem_valid    in   1              memory completion, sampled only in WAIT
//  i_mem_rdata    in   32             memory read data, valid with i_mem_valid
// BEHAVIOUR
//  Reset: async on i_rst_n low. state=IDLE, all outputs 0, last_grant=NUM_HARTS-1 (hart 0 wins first).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Only one transaction is in flight.
//  IDLE: if any i_req_valid, pick winner = first valid hart after last_grant, modulo NUM_HARTS.
//    Assert o_req_ready[winner] this cycle; latch ren/wen/addr/wdata/mask. Next state ISSUE.
//  ISSUE: drive o_mem_* from the latch for exactly 1 cycle. Next state WAIT.
//    Illegal request (ren&wen both 1, or both 0): no strobe, err latched, next state RESP.
//  WAIT: o_mem_* strobes 0, address/data held. On i_mem_valid: latch rdata (0 if write). Next state RESP.
//    No timeout: a hung memory stalls WAIT indefinitely.
//  RESP: o_rsp_valid[winner]=1, o_rsp_rdata and o_rsp_err driven. last_grant<=winner. Next state IDLE.
//  Minimum latency, legal request: accept T0, strobe T1, i_mem_valid at T2, response T3, next accept T4.
//  Requests arriving in ISSUE/WAIT/RESP are not accepted and wait for IDLE. No request is dropped.
//  Fairness: a hart with i_req_valid held waits at most NUM_HARTS-1 other grants.
//  o_mem_ren and o_mem_wen are never both 1. o_mem_addr[1:0] is always 2'b00.
//  o_rsp_rdata, o_rsp_err and o_rsp_valid are 0 outside RESP.
//  i_mem_valid outside WAIT is ignored.
//  Reset mid-transaction: aborts it with no response; the memory may still complete and is ignored.
// TESTING
//  1. Hart1 read addr 0x1006 mask 0b1100, mem returns 0xDEADBEEF after 1 cycle
//     -> ready[1] T0, mem_ren with addr 0x1004 T1, rsp_valid[1] with 0xDEADBEEF T3.
//  2. All 3 harts request from reset and hold -> grant order 0,1,2,0; each o_req_ready one-hot.
//  3. Hart2 write 0x0000AB00 mask 0b0010, memory latency 5 cycles
//     -> single mem_wen pulse, WAIT held 5 cycles, rsp_valid[2] with rdata 0, err 0.
//  4. Hart0 ren=1 and wen=1 -> no mem strobe, rsp_valid[0] with err=1, rdata 0.
//  5. i_rst_n low during WAIT -> outputs 0 immediately; next request goes to hart 0; late i_mem_valid ignored.
//  6. Hart0 requests continuously while hart2 requests once -> hart2 granted no later than the 2nd grant after its request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one variable-latency data-memory port among NUM_HARTS harts.
// One transaction in flight: IDLE (accept) -> ISSUE (strobe) -> WAIT (memory) -> RESP (reply).
module dmem_arbiter #(
    parameter int NUM_HARTS = 3,
    parameter int ADDR_W    = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_HARTS-1:0]        i_req_valid,
    input  logic [NUM_HARTS-1:0]        i_req_ren,
    input  logic [NUM_HARTS-1:0]        i_req_wen,
    input  logic [NUM_HARTS*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_HARTS*32-1:0]     i_req_wdata,
    input  logic [NUM_HARTS*4-1:0]      i_req_mask,
    output logic [NUM_HARTS-1:0]        o_req_ready,
    output logic [NUM_HARTS-1:0]        o_rsp_valid,
    output logic [31:0]                 o_rsp_rdata,
    output logic                        o_rsp_err,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic                        o_mem_ren,
    output logic                        o_mem_wen,
    output logic [31:0]                 o_mem_wdata,
    output logic [3:0]                  o_mem_mask,
    input  logic                        i_mem_valid,
    input  logic [31:0]                 i_mem_rdata
);

    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [HW-1:0]      last_grant;
    logic [HW-1:0]      grant_idx;
    logic               lat_ren;
    logic               lat_err;

    logic [HW-1:0]      cand;
    logic [HW-1:0]      winner;
    logic               any_valid;
    logic               sel_ren;
    logic               sel_wen;
    logic [ADDR_W-3:0]  sel_addr_hi;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_mask;

    // Scan harts starting just after the previous winner so every requester gets a turn.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cand      = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            cand = HW'((int'(last_grant) + k) % NUM_HARTS);
            if (!any_valid && i_req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
        sel_ren     = i_req_ren[winner];
        sel_wen     = i_req_wen[winner];
        sel_addr_hi = i_req_addr[winner*ADDR_W + 2 +: ADDR_W-2];
        sel_wdata   = i_req_wdata[winner*32 +: 32];
        sel_mask    = i_req_mask[winner*4 +: 4];

        o_req_ready = '0;
        if (state == IDLE && any_valid && i_rst_n)
            o_req_ready[winner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            last_grant  <= HW'(NUM_HARTS - 1);
            grant_idx   <= '0;
            lat_ren     <= 1'b0;
            lat_err     <= 1'b0;
            o_rsp_valid <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_idx   <= winner;
                        lat_ren     <= sel_ren;
                        lat_err     <= (sel_ren == sel_wen);
                        // Strobes are loaded here so they are high during the ISSUE cycle;
                        // an illegal ren/wen combination leaves both low.
                        o_mem_ren   <= sel_ren & ~sel_wen;
                        o_mem_wen   <= sel_wen & ~sel_ren;
                        o_mem_addr  <= {sel_addr_hi, 2'b00};
                        o_mem_wdata <= sel_wdata;
                        o_mem_mask  <= sel_mask;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_mem_ren <= 1'b0;
                    o_mem_wen <= 1'b0;
                    if (lat_err) begin
                        o_rsp_valid <= NUM_HARTS'(1) << grant_idx;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_valid) begin
                        o_rsp_valid <= NUM_HARTS'(1) << grant_idx;
                        o_rsp_rdata <= lat_ren ? i_mem_rdata : 32'h0;
                        o_rsp_err   <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    o_rsp_valid <= '0;
                    o_rsp_rdata <= '0;
                    o_rsp_err   <= 1'b0;
                    last_grant  <= grant_idx;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: latency, round-robin order, illegal requests,
// mid-transaction reset and fairness, with a small latency-programmable memory responder.
module tb_dmem_arbiter;

    localparam int N = 3;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    i_req_ren;
    logic [N-1:0]    i_req_wen;
    logic [N*32-1:0] i_req_addr;
    logic [N*32-1:0] i_req_wdata;
    logic [N*4-1:0]  i_req_mask;
    logic [N-1:0]    o_req_ready;
    logic [N-1:0]    o_rsp_valid;
    logic [31:0]     o_rsp_rdata;
    logic            o_rsp_err;
    logic [31:0]     o_mem_addr;
    logic            o_mem_ren;
    logic            o_mem_wen;
    logic [31:0]     o_mem_wdata;
    logic [3:0]      o_mem_mask;
    logic            i_mem_valid = 1'b0;
    logic [31:0]     i_mem_rdata;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.NUM_HARTS(N), .ADDR_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_ren   (i_req_ren),
        .i_req_wen   (i_req_wen),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_mask  (i_req_mask),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_mask  (o_mem_mask),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: i_mem_valid rises mem_lat cycles after a strobe, for one cycle.
    int mem_lat = 1;
    int mem_cnt = 0;
    always @(negedge i_clk) begin
        i_mem_valid = 1'b0;
        if (mem_cnt != 0) begin
            mem_cnt--;
            if (mem_cnt == 0) i_mem_valid = 1'b1;
        end
        if (i_rst_n && (o_mem_ren || o_mem_wen)) mem_cnt = mem_lat;
    end

    // Invariant monitor.
    int v_onehot = 0, v_both = 0, v_lsb = 0, ren_pulses = 0, wen_pulses = 0;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (!$onehot0(o_req_ready)) v_onehot++;
            if (o_mem_ren && o_mem_wen) v_both++;
            if (o_mem_addr[1:0] != 2'b00) v_lsb++;
            if (o_mem_ren) ren_pulses++;
            if (o_mem_wen) wen_pulses++;
        end
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int h, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        i_req_ren[h]          = ren;
        i_req_wen[h]          = wen;
        i_req_addr[h*32 +: 32]  = addr;
        i_req_wdata[h*32 +: 32] = wdata;
        i_req_mask[h*4 +: 4]    = mask;
        i_req_valid[h]        = 1'b1;
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        next_cycle();
        next_cycle();
        i_rst_n = 1'b1;
        next_cycle();
    endtask

    // Returns one cycle after the grant (ISSUE cycle).
    task automatic wait_grant(input string tag, input logic [N-1:0] exp);
        bit found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge i_clk);
            if (|o_req_ready) begin
                found = 1'b1;
                check({tag, "_ready"}, 32'(o_req_ready), 32'(exp));
            end
            next_cycle();
        end
        if (!found) check({tag, "_grant_timeout"}, 32'd0, 32'd1);
    endtask

    // Returns one cycle after the response; exp_cyc counts cycles from the call to the response.
    task automatic wait_rsp(input string tag, input logic [N-1:0] exp_v, input logic [31:0] exp_d,
                            input logic exp_e, input int exp_cyc);
        bit found = 1'b0;
        int c = 0;
        while (!found && c < 40) begin
            @(negedge i_clk);
            c++;
            if (|o_rsp_valid) begin
                found = 1'b1;
                check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'(exp_v));
                check({tag, "_rsp_rdata"}, o_rsp_rdata, exp_d);
                check({tag, "_rsp_err"}, 32'(o_rsp_err), 32'(exp_e));
                check({tag, "_rsp_latency"}, 32'(c), 32'(exp_cyc));
            end
            next_cycle();
        end
        if (!found) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    int          snap_ren, snap_wen;
    bit          late_rsp;
    logic [N-1:0] order_oh [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_ren   = '0;
        i_req_wen   = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_req_mask  = '0;
        i_mem_rdata = '0;
        next_cycle();
        next_cycle();

        // Reset state
        @(negedge i_clk);
        check("reset_ready", 32'(o_req_ready), 32'd0);
        check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset_mem_strobes", 32'({o_mem_ren, o_mem_wen}), 32'd0);
        check("reset_mem_addr", o_mem_addr, 32'd0);
        next_cycle();
        i_rst_n = 1'b1;
        next_cycle();

        // 1: hart1 read, exact cycle-by-cycle latency
        mem_lat     = 1;
        i_mem_rdata = 32'hDEADBEEF;
        set_req(1, 1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'b1100);
        @(negedge i_clk);
        check("t1_ready_T0", 32'(o_req_ready), 32'b010);
        next_cycle();
        i_req_valid[1] = 1'b0;
        @(negedge i_clk);
        check("t1_mem_ren_T1", 32'(o_mem_ren), 32'd1);
        check("t1_mem_wen_T1", 32'(o_mem_wen), 32'd0);
        check("t1_mem_addr_T1", o_mem_addr, 32'h0000_1004);
        check("t1_mem_mask_T1", 32'(o_mem_mask), 32'hC);
        next_cycle();
        @(negedge i_clk);
        check("t1_rsp_valid_T2", 32'(o_rsp_valid), 32'd0);
        check("t1_mem_ren_T2", 32'(o_mem_ren), 32'd0);
        check("t1_mem_addr_held_T2", o_mem_addr, 32'h0000_1004);
        next_cycle();
        @(negedge i_clk);
        check("t1_rsp_valid_T3", 32'(o_rsp_valid), 32'b010);
        check("t1_rsp_rdata_T3", o_rsp_rdata, 32'hDEADBEEF);
        check("t1_rsp_err_T3", 32'(o_rsp_err), 32'd0);
        next_cycle();
        @(negedge i_clk);
        check("t1_rsp_valid_T4", 32'(o_rsp_valid), 32'd0);
        check("t1_rsp_rdata_T4", o_rsp_rdata, 32'd0);
        next_cycle();

        // 2: all harts request from reset and hold
        do_reset();
        i_mem_rdata = 32'h1111_2222;
        for (int h = 0; h < N; h++) set_req(h, 1'b1, 1'b0, 32'h100 * (h + 1), 32'h0, 4'hF);
        for (int g = 0; g < 4; g++) begin
            wait_grant($sformatf("t2_grant%0d", g), order_oh[g]);
            wait_rsp($sformatf("t2_grant%0d", g), order_oh[g], 32'h1111_2222, 1'b0, 3);
        end
        i_req_valid = '0;
        next_cycle();

        // 3: hart2 write with 5-cycle memory latency
        mem_lat     = 5;
        i_mem_rdata = 32'hCAFE_F00D;
        snap_wen    = wen_pulses;
        set_req(2, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_AB00, 4'b0010);
        wait_grant("t3", 3'b100);
        i_req_valid[2] = 1'b0;
        @(negedge i_clk);
        check("t3_mem_wen", 32'(o_mem_wen), 32'd1);
        check("t3_mem_ren", 32'(o_mem_ren), 32'd0);
        check("t3_mem_wdata", o_mem_wdata, 32'h0000_AB00);
        check("t3_mem_mask", 32'(o_mem_mask), 32'b0010);
        next_cycle();
        wait_rsp("t3", 3'b100, 32'h0, 1'b0, 6);
        check("t3_wen_pulses", 32'(wen_pulses - snap_wen), 32'd1);

        // 4: hart0 illegal ren&wen
        snap_ren = ren_pulses;
        snap_wen = wen_pulses;
        set_req(0, 1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF);
        wait_grant("t4", 3'b001);
        i_req_valid[0] = 1'b0;
        @(negedge i_clk);
        check("t4_no_strobe", 32'({o_mem_ren, o_mem_wen}), 32'd0);
        next_cycle();
        wait_rsp("t4", 3'b001, 32'h0, 1'b1, 1);
        check("t4_no_pulses", 32'((ren_pulses - snap_ren) + (wen_pulses - snap_wen)), 32'd0);

        // 5: reset during WAIT of a hart1 read
        mem_lat     = 5;
        i_mem_rdata = 32'h55AA_55AA;
        set_req(1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
        wait_grant("t5_pre", 3'b010);
        next_cycle();
        next_cycle();
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_mem_addr", o_mem_addr, 32'd0);
        check("t5_rst_ready", 32'(o_req_ready), 32'd0);
        check("t5_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("t5_rst_strobes", 32'({o_mem_ren, o_mem_wen}), 32'd0);
        i_req_valid = '0;
        next_cycle();
        next_cycle();
        i_rst_n  = 1'b1;
        late_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (|o_rsp_valid) late_rsp = 1'b1;
            next_cycle();
        end
        check("t5_late_mem_ignored", 32'(late_rsp), 32'd0);
        mem_lat = 1;
        set_req(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 32'h0000_5100, 32'h0, 4'hF);
        wait_grant("t5_post0", 3'b001);
        i_req_valid[0] = 1'b0;
        wait_rsp("t5_post0", 3'b001, 32'h55AA_55AA, 1'b0, 3);
        wait_grant("t5_post1", 3'b010);
        i_req_valid[1] = 1'b0;
        wait_rsp("t5_post1", 3'b010, 32'h55AA_55AA, 1'b0, 3);

        // 6: hart0 continuous, hart2 once
        do_reset();
        i_mem_rdata = 32'h0BAD_F00D;
        set_req(0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
        wait_grant("t6_first", 3'b001);
        set_req(2, 1'b1, 1'b0, 32'h0000_6200, 32'h0, 4'hF);
        wait_rsp("t6_first", 3'b001, 32'h0BAD_F00D, 1'b0, 3);
        wait_grant("t6_fair", 3'b100);
        i_req_valid[2] = 1'b0;
        wait_rsp("t6_fair", 3'b100, 32'h0BAD_F00D, 1'b0, 3);
        wait_grant("t6_back", 3'b001);
        i_req_valid[0] = 1'b0;
        wait_rsp("t6_back", 3'b001, 32'h0BAD_F00D, 1'b0, 3);

        check("inv_ready_onehot", 32'(v_onehot), 32'd0);
        check("inv_strobes_exclusive", 32'(v_both), 32'd0);
        check("inv_addr_aligned", 32'(v_lsb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
